// File: rtl/oup_writer_pkg.sv
// Shared definitions for the ITA output writer: address/dimension widths,
// writer state encoding and the byte-address type.
package ita_package;

    localparam int unsigned OupAddrWidth = 32;
    localparam int unsigned OupDimWidth  = 16;

    typedef enum logic [1:0] {
        OupIdle   = 2'd0,
        OupStream = 2'd1,
        OupDrain  = 2'd2,
        OupDone   = 2'd3
    } oup_writer_state_e;

    typedef logic [OupAddrWidth-1:0] oup_addr_t;

endpackage

// File: rtl/oup_writer_fifo.sv
// Small synchronous-reset FIFO used as the writer's address/data buffer.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH:0]   usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [ADDR_DEPTH-1:0]            rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0]            wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]              cnt_q, cnt_d;
    logic                             full_int, empty_int;
    logic                             do_push, do_pop;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + ADDR_DEPTH'(1);
    endfunction

    assign full_int  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
    assign empty_int = (cnt_q == '0);
    assign full_o    = full_int;
    assign empty_o   = empty_int && !(FALL_THROUGH && push_i);
    assign usage_o   = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        data_o   = mem_q[rd_ptr_q];
        do_push  = push_i && (!full_int || pop_i);
        do_pop   = pop_i && !empty_int;

        // Fall-through on an empty FIFO: a same-cycle pop consumes the input directly.
        if (FALL_THROUGH && empty_int && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                do_push = 1'b0;
                do_pop  = 1'b0;
            end
        end

        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (ADDR_DEPTH + 1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (ADDR_DEPTH + 1)'(1);
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/oup_writer.sv
// ITA output writer: accepts output beats column-tile-major and writes each
// beat to memory at base + row*stride + tile*beat_bytes through a 2-entry buffer.
module oup_writer
    import ita_package::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned WI        = 8,
    parameter int unsigned AddrWidth = OupAddrWidth,
    parameter int unsigned DimWidth  = OupDimWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [DimWidth-1:0]  seq_len_i,
    input  logic [DimWidth-1:0]  proj_len_i,
    input  logic [DimWidth-1:0]  row_stride_i,
    input  logic                 oup_valid_i,
    output logic                 oup_ready_o,
    input  logic [N*WI-1:0]      oup_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [N*WI-1:0]      mem_wdata_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned BeatWidth  = N * WI;
    localparam int unsigned EntryWidth = BeatWidth + AddrWidth;
    localparam int unsigned TileBytes  = N * WI / 8;

    oup_writer_state_e state_q, state_d;

    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] col_base_q, col_base_d;
    logic [DimWidth-1:0]  seq_len_q, seq_len_d;
    logic [DimWidth-1:0]  proj_len_q, proj_len_d;
    logic [DimWidth-1:0]  stride_q, stride_d;
    logic [DimWidth-1:0]  row_q, row_d;
    logic [DimWidth:0]    col_q, col_d;

    logic                  fifo_full, fifo_empty;
    logic [1:0]            fifo_usage;
    logic [EntryWidth-1:0] fifo_head;
    logic                  accept, pop, row_last, last_beat;

    assign oup_ready_o = (state_q == OupStream) && !fifo_full;
    assign accept      = oup_valid_i && oup_ready_o;
    assign mem_req_o   = !fifo_empty;
    assign pop         = mem_req_o && mem_gnt_i;
    assign mem_addr_o  = mem_req_o ? fifo_head[EntryWidth-1:BeatWidth] : '0;
    assign mem_wdata_o = mem_req_o ? fifo_head[BeatWidth-1:0] : '0;
    assign busy_o      = (state_q != OupIdle);
    assign done_o      = (state_q == OupDone);

    assign row_last  = (row_q == seq_len_q - DimWidth'(1));
    assign last_beat = row_last && ((col_q + (DimWidth + 1)'(N)) >= {1'b0, proj_len_q});

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (EntryWidth),
        .DEPTH        (2)
    ) i_buffer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  ({addr_q, oup_i}),
        .push_i  (accept),
        .data_o  (fifo_head),
        .pop_i   (pop)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        col_base_d = col_base_q;
        seq_len_d  = seq_len_q;
        proj_len_d = proj_len_q;
        stride_d   = stride_q;
        row_d      = row_q;
        col_d      = col_q;

        unique case (state_q)
            OupIdle: begin
                if (start_i) begin
                    seq_len_d  = seq_len_i;
                    proj_len_d = proj_len_i;
                    stride_d   = row_stride_i;
                    addr_d     = base_addr_i;
                    col_base_d = base_addr_i;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = (seq_len_i == '0 || proj_len_i == '0) ? OupDone : OupStream;
                end
            end
            OupStream: begin
                if (accept) begin
                    // Row wrap restarts from the next column tile's row-0 address.
                    if (row_last) begin
                        row_d      = '0;
                        col_d      = col_q + (DimWidth + 1)'(N);
                        col_base_d = col_base_q + AddrWidth'(TileBytes);
                        addr_d     = col_base_q + AddrWidth'(TileBytes);
                    end else begin
                        row_d  = row_q + DimWidth'(1);
                        addr_d = addr_q + AddrWidth'(stride_q);
                    end
                    if (last_beat) begin
                        state_d = OupDrain;
                    end
                end
            end
            OupDrain: begin
                // Leave once the buffer is empty after this cycle's grant.
                if (fifo_usage == 2'd0 || (fifo_usage == 2'd1 && mem_gnt_i)) begin
                    state_d = OupDone;
                end
            end
            OupDone: begin
                state_d = OupIdle;
            end
            default: begin
                state_d = OupIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= OupIdle;
            addr_q     <= '0;
            col_base_q <= '0;
            seq_len_q  <= '0;
            proj_len_q <= '0;
            stride_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_base_q <= col_base_d;
            seq_len_q  <= seq_len_d;
            proj_len_q <= proj_len_d;
            stride_q   <= stride_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

endmodule
